// File: rtl/jtframe_ddr_pkg.sv
// Shared definitions for the two-master DDR burst arbiter.
package jtframe_ddr_pkg;

    localparam int DDR_DW = 64;
    localparam int DDR_AW = 29;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/jtframe_ddr_arb_cnt.sv
// Beat counter for one burst: latches the burst length and flags the final beat.
// A requested length of zero is treated as a single beat.
module jtframe_ddr_arb_cnt #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [BW-1:0] load_len,
    input  logic          inc,
    output logic [BW:0]   cnt,
    output logic [BW:0]   len,
    output logic          done
);

    // Latch length and clear the count at burst start, then count beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            len <= '0;
        end else if (load) begin
            cnt <= '0;
            len <= (load_len == '0) ? {{BW{1'b0}}, 1'b1} : {1'b0, load_len};
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = inc && (cnt == len - 1'b1);

endmodule

// File: rtl/jtframe_ddr_arb2.sv
// Two-master burst arbiter in front of the single DDR port.
// The grant is held for a full burst; the losing master sees busy until it is served.
module jtframe_ddr_arb2 import jtframe_ddr_pkg::*; #(
    parameter int RR = 0,
    parameter int BW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              m0_busy,
    input  logic [BW-1:0]     m0_burstcnt,
    input  logic [DDR_AW-1:0] m0_addr,
    input  logic              m0_rd,
    input  logic              m0_we,
    input  logic [DDR_DW-1:0] m0_din,
    input  logic [7:0]        m0_be,
    output logic [DDR_DW-1:0] m0_dout,
    output logic              m0_dout_ready,
    output logic              m1_busy,
    input  logic [BW-1:0]     m1_burstcnt,
    input  logic [DDR_AW-1:0] m1_addr,
    input  logic              m1_rd,
    input  logic              m1_we,
    input  logic [DDR_DW-1:0] m1_din,
    input  logic [7:0]        m1_be,
    output logic [DDR_DW-1:0] m1_dout,
    output logic              m1_dout_ready,
    output logic              ddram_clk,
    input  logic              ddram_busy,
    output logic [BW-1:0]     ddram_burstcnt,
    output logic [DDR_AW-1:0] ddram_addr,
    output logic [DDR_DW-1:0] ddram_din,
    output logic [7:0]        ddram_be,
    output logic              ddram_rd,
    output logic              ddram_we,
    input  logic [DDR_DW-1:0] ddram_dout,
    input  logic              ddram_dout_ready,
    input  logic [7:0]        st_addr,
    output logic [7:0]        st_dout
);

    arb_state_t        state;
    logic [1:0]        state_bits;
    logic [1:0]        gnt;
    logic              last;
    logic              cmd_done;
    logic [DDR_AW-1:0] wr_addr;
    logic [BW-1:0]     wr_bc;

    logic              req0, req1, win, win_rd;
    logic [BW-1:0]     win_bc;
    logic [DDR_AW-1:0] win_addr;
    logic              sel_rd, sel_we;
    logic [BW-1:0]     sel_bc;
    logic [DDR_AW-1:0] sel_addr;
    logic [DDR_DW-1:0] sel_din;
    logic [7:0]        sel_be;

    logic              cnt_load, cnt_inc, cnt_done;
    logic [BW:0]       cnt, len;
    logic              unused_bits;

    assign ddram_clk  = clk;
    assign state_bits = state;

    // Pick the winner among the idle-time requests; rd takes precedence over we
    always_comb begin
        req0 = m0_rd | m0_we;
        req1 = m1_rd | m1_we;
        if (req0 && req1) win = (RR != 0) ? ~last : 1'b0;
        else              win = req1;
        win_rd   = win ? m1_rd       : m0_rd;
        win_bc   = win ? m1_burstcnt : m0_burstcnt;
        win_addr = win ? m1_addr     : m0_addr;
    end

    // Select the signals of whichever master currently holds the grant
    always_comb begin
        sel_rd   = gnt[1] ? m1_rd       : m0_rd;
        sel_we   = gnt[1] ? m1_we       : m0_we;
        sel_bc   = gnt[1] ? m1_burstcnt : m0_burstcnt;
        sel_addr = gnt[1] ? m1_addr     : m0_addr;
        sel_din  = gnt[1] ? m1_din      : m0_din;
        sel_be   = gnt[1] ? m1_be       : m0_be;
    end

    // Drive the memory port; writes keep the address and length captured at grant time
    always_comb begin
        ddram_rd       = (state == ST_RD) && !cmd_done && sel_rd;
        ddram_we       = (state == ST_WR) && sel_we;
        ddram_addr     = '0;
        ddram_burstcnt = '0;
        ddram_din      = '0;
        ddram_be       = '0;
        if (state == ST_RD) begin
            ddram_addr     = sel_addr;
            ddram_burstcnt = sel_bc;
        end else if (state == ST_WR) begin
            ddram_addr     = wr_addr;
            ddram_burstcnt = wr_bc;
        end
        if (gnt != 2'b00) begin
            ddram_din = sel_din;
            ddram_be  = sel_be;
        end
    end

    assign m0_busy       = ~gnt[0] | ddram_busy;
    assign m1_busy       = ~gnt[1] | ddram_busy;
    assign m0_dout       = ddram_dout;
    assign m1_dout       = ddram_dout;
    assign m0_dout_ready = ddram_dout_ready && gnt[0] && (state == ST_RD);
    assign m1_dout_ready = ddram_dout_ready && gnt[1] && (state == ST_RD);

    assign cnt_load = (state == ST_IDLE) && (req0 || req1);
    assign cnt_inc  = ((state == ST_RD) && ddram_dout_ready) ||
                      ((state == ST_WR) && ddram_we && !ddram_busy);

    jtframe_ddr_arb_cnt #(.BW(BW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_len (win_bc),
        .inc      (cnt_inc),
        .cnt      (cnt),
        .len      (len),
        .done     (cnt_done)
    );

    // Arbitration FSM: grant in IDLE, hold for the burst, one GAP cycle afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= 2'b00;
            last     <= 1'b1;
            cmd_done <= 1'b0;
            wr_addr  <= '0;
            wr_bc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        gnt      <= win ? 2'b10 : 2'b01;
                        last     <= win;
                        cmd_done <= 1'b0;
                        wr_addr  <= win_addr;
                        wr_bc    <= win_bc;
                        state    <= win_rd ? ST_RD : ST_WR;
                    end
                end
                ST_RD: begin
                    if (ddram_rd && !ddram_busy) cmd_done <= 1'b1;
                    if (cnt_done) begin
                        gnt   <= 2'b00;
                        state <= ST_GAP;
                    end
                end
                ST_WR: begin
                    if (cnt_done) begin
                        gnt   <= 2'b00;
                        state <= ST_GAP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered status readout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_dout <= 8'd0;
        end else begin
            case (st_addr[3:0])
                4'd0:    st_dout <= {state_bits, gnt, last, ddram_rd, ddram_we, ddram_busy};
                4'd1:    st_dout <= cnt[7:0];
                4'd2:    st_dout <= len[7:0];
                default: st_dout <= 8'd0;
            endcase
        end
    end

    assign unused_bits = ^{st_addr[7:4], cnt, len};

endmodule

// File: tb/tb_jtframe_ddr_arb2.sv
// Bench for the DDR arbiter: randomized masters and memory, checked each cycle
// against a burst-level model of who owns the port and how many beats remain.
module tb_jtframe_ddr_arb2;

    localparam int BW = 8;
    localparam int RR = 1;
    localparam int PH_IDLE = 0;
    localparam int PH_XFER = 1;
    localparam int PH_GAP  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          m0_busy, m1_busy;
    logic [BW-1:0] m0_burstcnt, m1_burstcnt;
    logic [28:0]   m0_addr, m1_addr;
    logic          m0_rd, m1_rd, m0_we, m1_we;
    logic [63:0]   m0_din, m1_din, m0_dout, m1_dout;
    logic [7:0]    m0_be, m1_be;
    logic          m0_dout_ready, m1_dout_ready;
    logic          ddram_clk, ddram_busy, ddram_rd, ddram_we, ddram_dout_ready;
    logic [BW-1:0] ddram_burstcnt;
    logic [28:0]   ddram_addr;
    logic [63:0]   ddram_din, ddram_dout;
    logic [7:0]    ddram_be, st_addr, st_dout;

    // Bench-side masters and memory
    int            rd_reps[2];
    int            wr_beats[2];
    logic [BW-1:0] bc[2];
    logic [28:0]   base_addr[2];
    bit            jitter_addr, busy_rand, stray_en;
    int            pending;
    logic [7:0]    st_sel;

    // Burst-level model of the port
    int            ph, own, len_m, beats, cyc;
    bit            is_rd, cmd_sent, last_m;
    logic [28:0]   h_addr;
    logic [BW-1:0] h_bc;
    int            grants[$];
    int            grant_cyc[$];
    int            last_beat_cyc[2];

    logic          e_busy0, e_busy1, e_rd, e_we, e_dr0, e_dr1;
    logic [BW-1:0] e_bc;
    logic [28:0]   e_addr;
    logic [63:0]   e_din;
    logic [7:0]    e_be;

    int dut_rdy0, dut_rdy1, dut_wr0, dut_wr1;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    jtframe_ddr_arb2 #(.RR(RR), .BW(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_busy(m0_busy), .m0_burstcnt(m0_burstcnt), .m0_addr(m0_addr), .m0_rd(m0_rd),
        .m0_we(m0_we), .m0_din(m0_din), .m0_be(m0_be), .m0_dout(m0_dout), .m0_dout_ready(m0_dout_ready),
        .m1_busy(m1_busy), .m1_burstcnt(m1_burstcnt), .m1_addr(m1_addr), .m1_rd(m1_rd),
        .m1_we(m1_we), .m1_din(m1_din), .m1_be(m1_be), .m1_dout(m1_dout), .m1_dout_ready(m1_dout_ready),
        .ddram_clk(ddram_clk), .ddram_busy(ddram_busy), .ddram_burstcnt(ddram_burstcnt),
        .ddram_addr(ddram_addr), .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_rd(ddram_rd),
        .ddram_we(ddram_we), .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
        .st_addr(st_addr), .st_dout(st_dout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int eff_len(input logic [BW-1:0] v);
        return (v == '0) ? 1 : int'(v);
    endfunction

    function automatic bit quiet();
        return rd_reps[0] == 0 && rd_reps[1] == 0 && wr_beats[0] == 0 && wr_beats[1] == 0 &&
               pending == 0 && ph == PH_IDLE;
    endfunction

    // Drive masters, memory and status select for the current cycle
    task automatic apply_stimulus();
        m0_rd = (rd_reps[0] > 0);
        m1_rd = (rd_reps[1] > 0);
        m0_we = (wr_beats[0] > 0);
        m1_we = (wr_beats[1] > 0);
        m0_burstcnt = bc[0];
        m1_burstcnt = bc[1];
        m0_addr = jitter_addr ? 29'($urandom) : base_addr[0];
        m1_addr = jitter_addr ? 29'($urandom) : base_addr[1];
        m0_din = {$urandom, $urandom};
        m1_din = {$urandom, $urandom};
        m0_be = 8'($urandom);
        m1_be = 8'($urandom);
        ddram_busy = busy_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        ddram_dout = {$urandom, $urandom};
        ddram_dout_ready = 1'b0;
        if (pending > 0) begin
            if ($urandom_range(0, 3) != 0) begin
                ddram_dout_ready = 1'b1;
                pending--;
            end
        end else if (stray_en && ph != PH_XFER && $urandom_range(0, 3) == 0) begin
            ddram_dout_ready = 1'b1;
        end
        st_addr = st_sel;
    endtask

    // What the port must show given the model's owner and progress
    task automatic predict();
        bit x;
        x = (ph == PH_XFER);
        e_busy0 = !(x && own == 0) || ddram_busy;
        e_busy1 = !(x && own == 1) || ddram_busy;
        e_rd    = x && is_rd && !cmd_sent && (own == 1 ? m1_rd : m0_rd);
        e_we    = x && !is_rd && (own == 1 ? m1_we : m0_we);
        e_addr  = !x ? 29'd0 : (is_rd ? (own == 1 ? m1_addr : m0_addr) : h_addr);
        e_bc    = !x ? '0 : (is_rd ? (own == 1 ? m1_burstcnt : m0_burstcnt) : h_bc);
        e_din   = !x ? 64'd0 : (own == 1 ? m1_din : m0_din);
        e_be    = !x ? 8'd0 : (own == 1 ? m1_be : m0_be);
        e_dr0   = x && is_rd && own == 0 && ddram_dout_ready;
        e_dr1   = x && is_rd && own == 1 && ddram_dout_ready;
    endtask

    task automatic check_output();
        predict();
        check("m0_busy", m0_busy, e_busy0);
        check("m1_busy", m1_busy, e_busy1);
        check("ddram_rd", ddram_rd, e_rd);
        check("ddram_we", ddram_we, e_we);
        check("ddram_addr", ddram_addr, e_addr);
        check("ddram_burstcnt", ddram_burstcnt, e_bc);
        check("ddram_din", ddram_din, e_din);
        check("ddram_be", ddram_be, e_be);
        check("m0_dout_ready", m0_dout_ready, e_dr0);
        check("m1_dout_ready", m1_dout_ready, e_dr1);
        check("m0_dout", m0_dout, ddram_dout);
        check("m1_dout", m1_dout, ddram_dout);
        if (m0_dout_ready) dut_rdy0++;
        if (m1_dout_ready) dut_rdy1++;
        if (ddram_we && !ddram_busy && !m0_busy) dut_wr0++;
        if (ddram_we && !ddram_busy && !m1_busy) dut_wr1++;
    endtask

    // Advance masters, memory and the model across the coming clock edge
    task automatic advance_model();
        bit acc_rd, acc_we, r0, r1;
        int w;
        acc_rd = e_rd && !ddram_busy;
        acc_we = e_we && !ddram_busy;
        if (acc_rd) begin
            rd_reps[own]--;
            pending += eff_len(e_bc);
        end
        if (acc_we) begin
            wr_beats[own]--;
            last_beat_cyc[own] = cyc;
        end
        case (ph)
            PH_IDLE: begin
                r0 = m0_rd || m0_we;
                r1 = m1_rd || m1_we;
                if (r0 || r1) begin
                    w = (r0 && r1) ? ((RR != 0) ? int'(!last_m) : 0) : (r1 ? 1 : 0);
                    last_m   = (w == 1);
                    own      = w;
                    is_rd    = (w == 1) ? m1_rd : m0_rd;
                    len_m    = eff_len((w == 1) ? m1_burstcnt : m0_burstcnt);
                    h_addr   = (w == 1) ? m1_addr : m0_addr;
                    h_bc     = (w == 1) ? m1_burstcnt : m0_burstcnt;
                    beats    = 0;
                    cmd_sent = 0;
                    ph       = PH_XFER;
                    grants.push_back(w);
                    grant_cyc.push_back(cyc);
                end
            end
            PH_XFER: begin
                if (acc_rd) cmd_sent = 1;
                if (is_rd ? ddram_dout_ready : acc_we) beats++;
                if (beats == len_m) ph = PH_GAP;
            end
            default: ph = PH_IDLE;
        endcase
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        apply_stimulus();
        #1;
        check_output();
        advance_model();
    endtask

    task automatic run_until(input string name, input int limit);
        int n;
        n = 0;
        while (!quiet() && n < limit) begin
            step();
            n++;
        end
        if (!quiet()) begin
            n_checks++;
            $display("[TB] FAIL %s_timeout: still active after %0d cycles, required idle", name, limit);
        end
        step();
        step();
    endtask

    task automatic status_check(input string name, input logic [7:0] sel, input logic [7:0] exp);
        st_sel = sel;
        step();
        step();
        check(name, st_dout, exp);
    endtask

    task automatic do_reset();
        rd_reps = '{0, 0};
        wr_beats = '{0, 0};
        pending = 0;
        busy_rand = 0;
        stray_en = 0;
        jitter_addr = 0;
        st_sel = 8'd0;
        ph = PH_IDLE;
        apply_stimulus();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        own = 0; beats = 0; len_m = 1; is_rd = 0; cmd_sent = 0; last_m = 1;
        h_addr = '0; h_bc = '0; cyc = 0;
        grants.delete();
        grant_cyc.delete();
        last_beat_cyc = '{0, 0};
        dut_rdy0 = 0; dut_rdy1 = 0; dut_wr0 = 0; dut_wr1 = 0;
    endtask

    initial begin
        int n;
        bc = '{8'd0, 8'd0};
        base_addr = '{29'h0123456, 29'h1ABCDEF};
        do_reset();

        // Reset values
        check("rst_m0_busy", m0_busy, 1'b1);
        check("rst_m1_busy", m1_busy, 1'b1);
        check("rst_ddram_rd", ddram_rd, 1'b0);
        status_check("rst_status0", 8'd0, 8'h08);

        // Single 128-beat read by m0 with stray pulses around it
        rd_reps[0] = 1; bc[0] = 8'h80; stray_en = 1;
        run_until("t1", 1000);
        stray_en = 0;
        check("t1_m0_pulses", dut_rdy0, 128);
        check("t1_m1_pulses", dut_rdy1, 0);
        check("t1_grants", grants.size(), 1);
        status_check("t1_status0", 8'd0, 8'h00);
        status_check("t1_cnt", 8'd1, 8'h80);
        status_check("t1_len", 8'd2, 8'h80);
        status_check("t1_other", 8'd7, 8'h00);

        // m0 write and m1 read requested together
        do_reset();
        wr_beats[0] = 128; bc[0] = 8'h80; rd_reps[1] = 1; bc[1] = 8'd8;
        run_until("t2", 2000);
        check("t2_grants", grants.size(), 2);
        check("t2_first", grants[0], 0);
        check("t2_second", grants[1], 1);
        check("t2_m0_beats", dut_wr0, 128);
        check("t2_gap", grant_cyc[1] - last_beat_cyc[0], 2);
        check("t2_m1_pulses", dut_rdy1, 8);

        // Round-robin with both masters reading 4-beat bursts continuously
        do_reset();
        rd_reps = '{2, 2}; bc = '{8'd4, 8'd4};
        run_until("t3", 1000);
        check("t3_grants", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++) check("t3_order", grants[i], i % 2);

        // Write under random memory stalls with a wandering master address
        do_reset();
        wr_beats[0] = 16; bc[0] = 8'd16; busy_rand = 1; jitter_addr = 1;
        run_until("t4", 1000);
        check("t4_beats", dut_wr0, 16);

        // Zero-length bursts from m1
        do_reset();
        rd_reps[1] = 1; bc[1] = 8'd0;
        run_until("t5r", 200);
        check("t5_rd_pulses", dut_rdy1, 1);
        wr_beats[1] = 1;
        run_until("t5w", 200);
        check("t5_wr_beats", dut_wr1, 1);
        check("t5_grants", grants.size(), 2);

        // Random mixes of traffic
        do_reset();
        for (int r = 0; r < 15; r++) begin
            busy_rand = 1; stray_en = 1;
            jitter_addr = 1'($urandom_range(0, 1));
            for (int i = 0; i < 2; i++) begin
                bc[i] = 8'($urandom_range(0, 6));
                case ($urandom_range(0, 2))
                    1: rd_reps[i] = $urandom_range(1, 2);
                    2: wr_beats[i] = eff_len(bc[i]) * $urandom_range(1, 2);
                    default: ;
                endcase
            end
            run_until("rand", 2000);
        end

        // Reset in the middle of a long read
        do_reset();
        rd_reps[0] = 1; bc[0] = 8'h80;
        n = 0;
        while (!(ph == PH_XFER && beats >= 40) && n < 1000) begin
            step();
            n++;
        end
        check("t6_mid_burst", (ph == PH_XFER && beats >= 40), 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_m0_busy", m0_busy, 1'b1);
        check("t6_m1_busy", m1_busy, 1'b1);
        check("t6_ddram_rd", ddram_rd, 1'b0);
        check("t6_ddram_we", ddram_we, 1'b0);
        check("t6_addr", ddram_addr, 29'd0);
        check("t6_dout_ready", m0_dout_ready, 1'b0);
        check("t6_st_dout", st_dout, 8'd0);
        do_reset();
        rd_reps[0] = 1; bc[0] = 8'd4;
        run_until("t6", 200);
        check("t6_regrant", grants.size(), 1);
        check("t6_owner", grants[0], 0);
        check("t6_pulses", dut_rdy0, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
